// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter steering one word per cycle through a 2:1 mux
// into a valid/ready output register, with bounded burst ownership.
module mux_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic [1:0]       gnt,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_last;
  logic             r_sel;
  logic             r_valid;
  logic [WIDTH-1:0] r_dout;

  logic w_can_load;
  logic w_owned;
  logic w_owner;
  logic w_keep;
  logic w_win;
  logic w_go;

  always_comb begin
    w_can_load = !r_valid || dout_ready;
    w_owned    = (r_state != S_IDLE);
    w_owner    = (r_state == S_OWN1);
    // Owner keeps the mux until its burst budget is spent, unless nobody else wants it.
    w_keep     = w_owned && req[w_owner] && ((r_cnt < MAX_CNT) || !req[~w_owner]);
    if (w_keep)
      w_win = w_owner;
    else if (&req)
      w_win = ~r_last;
    else
      w_win = req[1];
    // Held low during reset so no grant is visible before the first edge.
    w_go = rst_n && w_can_load && (|req);
    gnt  = w_go ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_valid <= 1'b0;
      r_dout  <= '0;
    end else if (w_go) begin
      r_dout  <= w_win ? din1 : din0;
      r_sel   <= w_win;
      r_valid <= 1'b1;
      r_last  <= w_win;
      r_state <= w_win ? S_OWN1 : S_OWN0;
      if (w_owned && (w_owner == w_win) && (r_last == w_win))
        r_cnt <= (r_cnt == MAX_CNT) ? r_cnt : r_cnt + CW'(1);
      else
        r_cnt <= CW'(1);
    end else if (w_can_load) begin
      // No requests while the register can take a word: drain and go idle.
      r_valid <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end
  end

  assign sel        = r_sel;
  assign dout       = r_dout;
  assign dout_valid = r_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized bench for mux_rr_arbiter: two instances (MAX_BURST 4 and 1) share stimulus
// and are compared against a per-instance behavioural arbitration model.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] din0;
  logic [7:0] din1;
  logic       dout_ready;

  logic [1:0] gnt_a   [2];
  logic       sel_a   [2];
  logic [7:0] dout_a  [2];
  logic       valid_a [2];

  int total = 0;
  int bad   = 0;

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din0(din0), .din1(din1),
    .gnt(gnt_a[0]), .sel(sel_a[0]), .dout(dout_a[0]), .dout_valid(valid_a[0]),
    .dout_ready(dout_ready)
  );

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .din0(din0), .din1(din1),
    .gnt(gnt_a[1]), .sel(sel_a[1]), .dout(dout_a[1]), .dout_valid(valid_a[1]),
    .dout_ready(dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state per instance: owner -1 means idle.
  int         mb      [2] = '{4, 1};
  int         m_owner [2];
  int         m_cnt   [2];
  int         m_last  [2];
  logic       m_valid [2];
  logic       m_sel   [2];
  logic [7:0] m_dout  [2];
  int         tie_idx = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_cnt[k] = 0; m_last[k] = 1;
      m_valid[k] = 1'b0; m_sel[k] = 1'b0; m_dout[k] = 8'h00;
    end
  endtask

  // One cycle: inputs already driven; check at negedge, advance model at posedge.
  task automatic step();
    int w  [2];
    bit go [2];
    logic [1:0] eg;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit can_load;
      can_load = !m_valid[k] || dout_ready;
      go[k] = can_load && (req != 2'b00);
      w[k]  = 0;
      if (go[k]) begin
        if (m_owner[k] >= 0 && req[m_owner[k]] &&
            (m_cnt[k] < mb[k] || !req[1 - m_owner[k]]))
          w[k] = m_owner[k];
        else if (req == 2'b11)
          w[k] = 1 - m_last[k];
        else
          w[k] = req[0] ? 0 : 1;
      end
      eg = go[k] ? 2'(1 << w[k]) : 2'b00;
      chk($sformatf("gnt%0d", k), 32'(gnt_a[k]), 32'(eg));
      chk($sformatf("valid%0d", k), 32'(valid_a[k]), 32'(m_valid[k]));
      if (m_valid[k]) begin
        chk($sformatf("dout%0d", k), 32'(dout_a[k]), 32'(m_dout[k]));
        chk($sformatf("sel%0d", k), 32'(sel_a[k]), 32'(m_sel[k]));
      end
    end
    if (tie_idx >= 0) begin
      chk("tie_seq_mb4", 32'(gnt_a[0]), 32'(1 << ((tie_idx / 4) % 2)));
      chk("tie_seq_mb1", 32'(gnt_a[1]), 32'(1 << (tie_idx % 2)));
      tie_idx++;
    end
    $display("cyc t=%0t req=%b rdy=%b gnt=%b/%b dout=%h/%h v=%b/%b",
             $time, req, dout_ready, gnt_a[0], gnt_a[1], dout_a[0], dout_a[1],
             valid_a[0], valid_a[1]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (go[k]) begin
        m_cnt[k]   = (m_owner[k] == w[k] && m_last[k] == w[k]) ?
                     ((m_cnt[k] + 1 > mb[k]) ? mb[k] : m_cnt[k] + 1) : 1;
        m_owner[k] = w[k];
        m_last[k]  = w[k];
        m_dout[k]  = w[k] ? din1 : din0;
        m_sel[k]   = w[k][0];
        m_valid[k] = 1'b1;
      end else if (!m_valid[k] || dout_ready) begin
        m_valid[k] = 1'b0;
        m_owner[k] = -1;
        m_cnt[k]   = 0;
      end
    end
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_gnt%0d", k), 32'(gnt_a[k]), 32'd0);
      chk($sformatf("rst_valid%0d", k), 32'(valid_a[k]), 32'd0);
      chk($sformatf("rst_sel%0d", k), 32'(sel_a[k]), 32'd0);
      chk($sformatf("rst_dout%0d", k), 32'(dout_a[k]), 32'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      req        = 2'($urandom_range(0, 3));
      din0       = 8'($urandom);
      din1       = 8'($urandom);
      dout_ready = ($urandom_range(0, 3) != 0);
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; din0 = 8'h00; din1 = 8'h00; dout_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("init_valid%0d", k), 32'(valid_a[k]), 32'd0);
      chk($sformatf("init_dout%0d", k), 32'(dout_a[k]), 32'd0);
    end
    rst_n = 1'b1;

    // Single requester: no burst limit applies.
    req = 2'b01; din0 = 8'hA5; dout_ready = 1'b1;
    repeat (7) step();
    chk("single_dout", 32'(dout_a[0]), 32'hA5);
    chk("single_dout_mb1", 32'(dout_a[1]), 32'hA5);

    // Ties straight out of reset: requester 0 wins first.
    async_reset();
    req = 2'b11; dout_ready = 1'b1;
    tie_idx = 0;
    for (int i = 0; i < 12; i++) begin
      din0 = 8'($urandom); din1 = 8'($urandom);
      step();
    end
    tie_idx = -1;

    // Backpressure then release.
    dout_ready = 1'b0;
    repeat (3) step();
    dout_ready = 1'b1;
    repeat (2) step();

    // Owner drops mid-burst, then everyone leaves.
    async_reset();
    req = 2'b01; din0 = 8'h11;
    repeat (2) step();
    req = 2'b10; din1 = 8'h22;
    repeat (2) step();
    req = 2'b00;
    repeat (3) step();

    rand_steps(400);
    async_reset();
    rand_steps(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
